// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
package prog_loader_pkg;

  // Loader FSM encoding (3 bits, values fixed so traces stay readable)
  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_LO = 3'd1,
    LDR_DATA   = 3'd2,
    LDR_WRITE  = 3'd3,
    LDR_CHECK  = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERROR  = 3'd6
  } ldr_state_t;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // First word of the data region; also used by the control unit's inference read path
  localparam int unsigned DATA_REGION_BASE = 6300;

  // fast_clk cycles per UART bit, truncated
  function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte/frame-error pulses.
module prog_loader_uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 868
) (
  input  logic       fast_clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);

  rx_state_t        st, st_d;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Bring the asynchronous line into the fast_clk domain and keep one sample of history
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) st <= RX_IDLE;
    else        st <= st_d;
  end

  // Receiver next-state: start bit must still be low at half a bit time
  always_comb begin
    st_d = st;
    unique case (st)
      RX_IDLE:  if (rx_prev && !rx_sync) st_d = RX_START;
      RX_START: if (cnt == HALF_M1) st_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == FULL_M1 && bit_idx == 3'd7) st_d = RX_STOP;
      RX_STOP:  if (cnt == FULL_M1) st_d = RX_IDLE;
      default:  st_d = RX_IDLE;
    endcase
  end

  // Bit timing, shift register and delivery pulses
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: cnt <= (cnt == HALF_M1) ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked image over UART and writes it to memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 6300,
  parameter int unsigned WR_CYCLES = 4
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              top_en,
  output logic              loading,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
  localparam int unsigned WC_W       = $clog2(WR_CYCLES + 1);

  ldr_state_t      state, state_d;
  logic            byte_valid, frame_err;
  logic [7:0]      byte_data;
  logic [15:0]     len;
  logic [7:0]      len_hi;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_bytes;
  logic [7:0]      csum;
  logic            hold_valid;
  logic [7:0]      hold_data;
  logic [WC_W-1:0] wr_cnt;

  logic            in_valid, accept_state, consume, wr_last;
  logic [7:0]      in_data;
  logic [15:0]     n_len, words_next;
  logic            strobe_d, top_en_d, loading_d, load_err_d;

  prog_loader_uart_rx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_uart_rx (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // A byte parked during WRITE takes priority over a fresh one
  assign in_valid     = hold_valid || byte_valid;
  assign in_data      = hold_valid ? hold_data : byte_data;
  assign accept_state = (state == LDR_IDLE) || (state == LDR_LEN_LO) ||
                        (state == LDR_DATA) || (state == LDR_CHECK);
  assign consume      = accept_state && in_valid;
  assign n_len        = {len_hi, in_data};
  assign wr_last      = (state == LDR_WRITE) && (wr_cnt == WC_W'(WR_CYCLES - 1));
  assign words_next   = words_loaded + 16'd1;

  // Loader state register
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) state <= LDR_IDLE;
    else        state <= state_d;
  end

  // Loader next-state; a framing error aborts any load still in progress
  always_comb begin
    state_d = state;
    unique case (state)
      LDR_IDLE:   if (in_valid) state_d = LDR_LEN_LO;
      LDR_LEN_LO: begin
        if (in_valid) begin
          if (n_len > 16'(MAX_WORDS)) state_d = LDR_ERROR;
          else if (n_len == 16'd0)    state_d = LDR_CHECK;
          else                        state_d = LDR_DATA;
        end
      end
      LDR_DATA:   if (in_valid && byte_idx == 2'd3) state_d = LDR_WRITE;
      LDR_WRITE: begin
        if (byte_valid && hold_valid) state_d = LDR_ERROR;
        else if (wr_last)             state_d = (words_next == len) ? LDR_CHECK : LDR_DATA;
      end
      LDR_CHECK:  if (in_valid) state_d = (in_data == csum) ? LDR_DONE : LDR_ERROR;
      default:    state_d = state;
    endcase
    if (frame_err && state != LDR_DONE && state != LDR_ERROR) state_d = LDR_ERROR;
  end

  // Output targets: strobe follows the next state so it spans exactly the WRITE cycles
  always_comb begin
    strobe_d   = (state_d == LDR_WRITE);
    top_en_d   = (state == LDR_DONE);
    loading_d  = (state != LDR_DONE) && (state != LDR_ERROR);
    load_err_d = (state == LDR_ERROR);
  end

  // Datapath and registered outputs
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      len          <= '0;
      len_hi       <= '0;
      byte_idx     <= '0;
      asm_bytes    <= '0;
      csum         <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      wr_cnt       <= '0;
      words_loaded <= '0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      mem_din      <= '0;
      mem_en       <= 1'b0;
      mem_wen      <= 1'b0;
      top_en       <= 1'b0;
      loading      <= 1'b1;
      load_err     <= 1'b0;
    end else begin
      mem_en   <= strobe_d;
      mem_wen  <= strobe_d;
      top_en   <= top_en_d;
      loading  <= loading_d;
      load_err <= load_err_d;

      if (state == LDR_WRITE && byte_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= byte_data;
      end else if (consume && hold_valid) begin
        hold_valid <= byte_valid;
        hold_data  <= byte_data;
      end

      if (consume && state != LDR_CHECK) csum <= csum ^ in_data;

      if (consume && state == LDR_IDLE) len_hi <= in_data;
      if (consume && state == LDR_LEN_LO) begin
        len      <= n_len;
        byte_idx <= '0;
      end

      // Only the first three bytes are kept; the fourth goes straight into mem_din
      if (consume && state == LDR_DATA) begin
        asm_bytes <= {asm_bytes[15:0], in_data};
        byte_idx  <= byte_idx + 2'd1;
      end

      if (state == LDR_DATA && state_d == LDR_WRITE) begin
        mem_din  <= {asm_bytes, in_data};
        mem_addr <= ADDR_W'(BASE_ADDR + 32'(words_loaded));
        wr_cnt   <= '0;
      end

      if (state == LDR_WRITE) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) words_loaded <= words_next;
      end
    end
  end

endmodule
